// File: rtl/cr16_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cr16_pkg: opcodes, status bit indices and FSM states for the ALU.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cr16_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_ADDU  = 4'd1;
    localparam logic [3:0] OP_ADDC  = 4'd2;
    localparam logic [3:0] OP_ADDCU = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_SUBU  = 4'd5;
    localparam logic [3:0] OP_AND   = 4'd6;
    localparam logic [3:0] OP_OR    = 4'd7;
    localparam logic [3:0] OP_XOR   = 4'd8;
    localparam logic [3:0] OP_NOT   = 4'd9;
    localparam logic [3:0] OP_LSH   = 4'd10;
    localparam logic [3:0] OP_RSH   = 4'd11;
    localparam logic [3:0] OP_ALSH  = 4'd12;
    localparam logic [3:0] OP_ARSH  = 4'd13;
    localparam logic [3:0] OP_MUL   = 4'd14;
    localparam logic [3:0] OP_RSVD  = 4'd15;

    localparam int ST_C = 0;
    localparam int ST_L = 1;
    localparam int ST_F = 2;
    localparam int ST_Z = 3;
    localparam int ST_N = 4;
    localparam int ST_W = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // Only the unsigned arithmetic ops write the carry register directly;
    // MUL writes it from the multiplier when the product completes.
    function automatic logic op_writes_cst(input logic [3:0] op);
        return (op == OP_ADDU) || (op == OP_ADDCU) || (op == OP_SUBU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cr16_mul_iter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cr16_mul_iter: iterative shift-add unsigned multiplier, 1 bit/cycle. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module cr16_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_product
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (i_start) begin
            r_mcand  <= {{WIDTH{1'b0}}, i_a};
            r_mplier <= i_b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
        end else if (r_busy) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (r_cnt == CNT_LAST) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end else begin
            r_done <= 1'b0;
        end
    end

    assign o_done    = r_done;
    assign o_product = r_acc;

endmodule
`default_nettype wire

// File: rtl/cr16_alu_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cr16_alu_pipe: registered, handshaked CR16 ALU with carry chaining   |
// | and an iterative multiplier on opcode 14.         Revision: 1.0      |
// +----------------------------------------------------------------------+
module cr16_alu_pipe
    import cr16_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             I_CLK,
    input  logic             I_NRESET,
    input  logic             I_VALID,
    output logic             O_READY,
    input  logic [3:0]       I_OPCODE,
    input  logic [WIDTH-1:0] I_A,
    input  logic [WIDTH-1:0] I_B,
    output logic             O_VALID,
    input  logic             I_READY,
    output logic [WIDTH-1:0] O_C,
    output logic [4:0]       O_STATUS
);

    localparam int MSB = WIDTH - 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_valid;
    logic [WIDTH-1:0]   r_c;
    logic [ST_W-1:0]    r_status;
    logic               r_cst;

    logic               w_accept;
    logic               w_is_mul;
    logic               w_cin;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_sub;
    logic               w_add_ovf;
    logic               w_sub_ovf;
    logic [SHW-1:0]     w_sh;
    logic               w_big;
    logic [WIDTH-1:0]   w_res;
    logic [ST_W-1:0]    w_st;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_mul_c;

    assign O_READY  = (r_state == S_IDLE) || ((r_state == S_HOLD) && I_READY);
    assign w_accept = I_VALID && O_READY;
    assign w_is_mul = (I_OPCODE == OP_MUL);

    assign w_cin = ((I_OPCODE == OP_ADDC) || (I_OPCODE == OP_ADDCU)) ? r_cst : 1'b0;
    assign w_add = {1'b0, I_A} + {1'b0, I_B} + {{WIDTH{1'b0}}, w_cin};
    assign w_sub = {1'b0, I_B} - {1'b0, I_A};

    assign w_add_ovf = (I_A[MSB] == I_B[MSB]) && (w_add[MSB] != I_A[MSB]);
    assign w_sub_ovf = (I_A[MSB] != I_B[MSB]) && (w_sub[MSB] != I_B[MSB]);

    // Any shift-amount bit at or above SHW means a shift of WIDTH or more.
    assign w_sh  = I_B[SHW-1:0];
    assign w_big = |I_B[WIDTH-1:SHW];

    always_comb begin
        w_res = '0;
        w_st  = '0;
        unique case (I_OPCODE)
            OP_ADD, OP_ADDC: begin
                w_res       = w_add[WIDTH-1:0];
                w_st[ST_N]  = w_add[MSB];
                w_st[ST_F]  = w_add_ovf;
            end
            OP_ADDU, OP_ADDCU: begin
                w_res       = w_add[WIDTH-1:0];
                w_st[ST_C]  = w_add[WIDTH];
            end
            OP_SUB: begin
                w_res       = w_sub[WIDTH-1:0];
                w_st[ST_F]  = w_sub_ovf;
                w_st[ST_N]  = w_sub[MSB] ^ w_sub_ovf;
            end
            OP_SUBU: begin
                w_res       = w_sub[WIDTH-1:0];
                w_st[ST_C]  = w_sub[WIDTH];
                w_st[ST_L]  = w_sub[WIDTH];
            end
            OP_AND:  w_res = I_A & I_B;
            OP_OR:   w_res = I_A | I_B;
            OP_XOR:  w_res = I_A ^ I_B;
            OP_NOT:  w_res = ~I_A;
            OP_LSH, OP_ALSH: w_res = w_big ? '0 : (I_A << w_sh);
            OP_RSH:  w_res = w_big ? '0 : (I_A >> w_sh);
            OP_ARSH: w_res = w_big ? {WIDTH{I_A[MSB]}} : WIDTH'($signed(I_A) >>> w_sh);
            default: w_res = '0;
        endcase
        if ((I_OPCODE >= OP_AND) && (I_OPCODE <= OP_ARSH)) begin
            w_st[ST_N] = w_res[MSB];
        end
        if ((I_OPCODE != OP_MUL) && (I_OPCODE != OP_RSVD)) begin
            w_st[ST_Z] = ~|w_res;
        end
    end

    cr16_mul_iter #(
        .WIDTH     (WIDTH)
    ) u_mul (
        .i_clk     (I_CLK),
        .i_rst_n   (I_NRESET),
        .i_start   (w_accept && w_is_mul),
        .i_a       (I_A),
        .i_b       (I_B),
        .o_done    (w_mul_done),
        .o_product (w_prod)
    );

    assign w_mul_c = |w_prod[2*WIDTH-1:WIDTH];

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_is_mul ? S_MUL : S_HOLD;
                end
            end
            S_MUL: begin
                if (w_mul_done) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_accept) begin
                    w_state_nxt = w_is_mul ? S_MUL : S_HOLD;
                end else if (I_READY) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            r_state  <= S_IDLE;
            r_valid  <= 1'b0;
            r_c      <= '0;
            r_status <= '0;
            r_cst    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept && !w_is_mul) begin
                r_c      <= w_res;
                r_status <= w_st;
                r_valid  <= 1'b1;
                if (op_writes_cst(I_OPCODE)) begin
                    r_cst <= w_st[ST_C];
                end
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end else if ((r_state == S_MUL) && w_mul_done) begin
                r_c            <= w_prod[WIDTH-1:0];
                r_status       <= '0;
                r_status[ST_C] <= w_mul_c;
                r_status[ST_Z] <= ~|w_prod[WIDTH-1:0];
                r_cst          <= w_mul_c;
                r_valid        <= 1'b1;
            end else if ((r_state == S_HOLD) && I_READY) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign O_VALID  = r_valid;
    assign O_C      = r_c;
    assign O_STATUS = r_status;

endmodule
`default_nettype wire
